// File: rtl/seg_display_if.sv
// seg_display_if: requester-side bus of the shared seven-segment display.
// Ports: req/value driven by the producers (master); grant, led_id, nibble and blank
// driven by the arbiter (slave) toward the producers and the segment decoder.
interface seg_display_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]    req;
    logic [16*N_REQ-1:0] value;
    logic [N_REQ-1:0]    grant;
    logic [7:0]          led_id;
    logic [3:0]          nibble;
    logic                blank;
    modport master(output req, value, input grant, led_id, nibble, blank);
    modport slave(input req, value, output grant, led_id, nibble, blank);
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of a 4-digit muxed display, switching only at frame ends.
// Ports: clk, rst (async, active high); bus.slave carries req/value in and
// grant (one-hot owner), led_id (active-low digit strobe), nibble and blank out.
module seg_display_arbiter #(
    parameter int N_REQ       = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 200
) (
    input  logic         clk,
    input  logic         rst,
    seg_display_if.slave bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [1:0]      digit;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [HW-1:0]   hold_cnt;
    logic [15:0]     snap;
    logic [1:0]      nd;
    logic            tick;
    logic            frame_end;
    logic            keep;
    logic            found;
    logic [IW-1:0]   win;

    // Scan last+1 .. last+N_REQ; descending loop lets the nearest requester after last win.
    function automatic logic [IW:0] pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] l);
        logic [IW-1:0] c;
        pick = {1'b0, l};
        for (int k = N_REQ; k >= 1; k--) begin
            c = IW'((int'(l) + k) % N_REQ);
            if (r[c]) pick = {1'b1, c};
        end
    endfunction

    assign tick      = div_cnt == DW'(SCAN_DIV - 1);
    assign nd        = digit + 2'd1;
    assign frame_end = tick && digit == 2'd3;
    assign keep      = state == OWNED && bus.req[owner] && hold_cnt < HW'(HOLD_FRAMES - 1);
    assign {found, win} = pick(bus.req, last);

    // Everything visible moves on the same tick edge, so strobe, digit data and owner never skew.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            digit      <= '0;
            owner      <= '0;
            last       <= IW'(N_REQ - 1);
            hold_cnt   <= '0;
            snap       <= '0;
            bus.grant  <= '0;
            bus.led_id <= 8'hFE;
            bus.nibble <= '0;
            bus.blank  <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                digit      <= nd;
                bus.led_id <= {4'hF, ~(4'b0001 << nd)};
                if (!frame_end) begin
                    bus.nibble <= state == OWNED ? snap[{nd, 2'b00} +: 4] : 4'h0;
                end else if (keep) begin
                    hold_cnt   <= hold_cnt + 1'b1;
                    snap       <= bus.value[16*owner +: 16];
                    bus.nibble <= bus.value[16*owner +: 4];
                end else if (found) begin
                    state      <= OWNED;
                    owner      <= win;
                    last       <= win;
                    hold_cnt   <= '0;
                    snap       <= bus.value[16*win +: 16];
                    bus.grant  <= N_REQ'(1) << win;
                    bus.blank  <= 1'b0;
                    bus.nibble <= bus.value[16*win +: 4];
                end else begin
                    state      <= IDLE;
                    bus.grant  <= '0;
                    bus.blank  <= 1'b1;
                    bus.nibble <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed checks of scanning, round-robin ownership, release, snapshot and reset.
module tb_seg_display_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    seg_display_if #(.N_REQ(4)) bus();

    seg_display_arbiter #(.N_REQ(4), .SCAN_DIV(4), .HOLD_FRAMES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, 32'(bus.grant), 32'h0);
        chk({tag, ".blank"}, 32'(bus.blank), 32'h1);
        chk({tag, ".nibble"}, 32'(bus.nibble), 32'h0);
        chk({tag, ".led"}, 32'(bus.led_id), 32'hFE);
    endtask

    // Called at digit 0 of a frame; walks all four digits and leaves the bench at the next frame start.
    task automatic chk_frame(input string tag, input logic [3:0] g, input logic [15:0] v);
        logic [7:0] led [4];
        led = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s.d%0d.led", tag, d), 32'(bus.led_id), 32'(led[d]));
            chk($sformatf("%s.d%0d.grant", tag, d), 32'(bus.grant), 32'(g));
            chk($sformatf("%s.d%0d.blank", tag, d), 32'(bus.blank), 32'(g == 4'h0));
            chk($sformatf("%s.d%0d.nibble", tag, d), 32'(bus.nibble), g == 4'h0 ? 32'h0 : 32'(v[4*d +: 4]));
            step(4);
        end
    endtask

    initial begin
        bus.req   = '0;
        bus.value = '0;
        step(2);
        chk_idle("rst");
        rst = 1'b0;
        chk_frame("idle0", 4'h0, 16'h0);
        chk_frame("idle1", 4'h0, 16'h0);
        bus.req = 4'b0010;
        bus.value[31:16] = 16'h1234;
        chk_frame("idle2", 4'h0, 16'h0);
        chk_frame("own1a", 4'b0010, 16'h1234);
        chk_frame("own1b", 4'b0010, 16'h1234);
        chk_frame("own1c", 4'b0010, 16'h1234);
        chk_frame("own1d", 4'b0010, 16'h1234);
        step(8);
        chk("pre_rst.grant", 32'(bus.grant), 32'b0010);
        chk("pre_rst.nibble", 32'(bus.nibble), 32'h2);
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        step(1);
        rst = 1'b0;
        bus.req = 4'b0101;
        bus.value[15:0]  = 16'h1111;
        bus.value[47:32] = 16'h3333;
        chk_frame("rr_idle", 4'h0, 16'h0);
        chk_frame("rr0a", 4'b0001, 16'h1111);
        chk_frame("rr0b", 4'b0001, 16'h1111);
        chk_frame("rr2a", 4'b0100, 16'h3333);
        chk_frame("rr2b", 4'b0100, 16'h3333);
        bus.req = 4'b0001;
        chk_frame("rr0c", 4'b0001, 16'h1111);
        step(4);
        bus.req = 4'b0000;
        chk("drop.d1.nibble", 32'(bus.nibble), 32'h1);
        chk("drop.d1.grant", 32'(bus.grant), 32'b0001);
        step(4);
        chk("drop.d2.nibble", 32'(bus.nibble), 32'h1);
        step(4);
        chk("drop.d3.nibble", 32'(bus.nibble), 32'h1);
        chk("drop.d3.led", 32'(bus.led_id), 32'hF7);
        step(4);
        chk_idle("released");
        bus.req = 4'b0001;
        bus.value[15:0] = 16'hAAAA;
        chk_frame("snap_idle", 4'h0, 16'h0);
        chk("snap.d0.nibble", 32'(bus.nibble), 32'hA);
        step(8);
        bus.value[15:0] = 16'h5555;
        chk("snap.d2.nibble", 32'(bus.nibble), 32'hA);
        step(4);
        chk("snap.d3.nibble", 32'(bus.nibble), 32'hA);
        step(4);
        chk_frame("snap_new", 4'b0001, 16'h5555);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Round-robin controller that shares the 4-digit multiplexed seven-segment display between up to N_REQ requesters, each presenting a 16-bit, four-nibble value. Generates the scan tick and digit strobe, arbitrates ownership only at frame boundaries, and snapshots the owner's value once per frame so the display never tears. Sits between the value producers and the nibble-to-segment decoder that drives `out_led`.

## Interface

- `N_REQ`, 4: number of requesters, legal range 2..8.
- `SCAN_DIV`, 50000: `clk` cycles per digit slot, minimum 2.
- `HOLD_FRAMES`, 200: maximum consecutive frames one owner keeps the display while others wait, minimum 1.

- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  N_REQ: level request per requester; held high while the requester wants the display.
- `value`  in  16*N_REQ: requester i's value in bits [16i+15:16i]; nibble 0 is the rightmost digit.
- `grant`  out  N_REQ: one-hot current owner; all zero when idle.
- `led_id`  out  8: active-low digit select; bits [7:4] always 1.
- `nibble`  out  4: code for the currently selected digit, to the segment decoder.
- `blank`  out  1: 1 = no owner; the decoder drives all segments off.

## Operation

- Scan divider: `div_cnt` counts 0..SCAN_DIV-1 and wraps. `tick` is high for the one cycle when `div_cnt == SCAN_DIV-1`.
- Digit index: 2-bit `digit` increments on `tick` and wraps 3→0.
  - `led_id` = 8'hFE, FD, FB, F7 for digit 0..3.
  - `frame_end` = `tick` && `digit == 3`.
- FSM states: IDLE and OWNED. Internal registers: `owner` index, `last` pointer, `hold_cnt`, 16-bit `snap`.
- Arbitration happens only on `frame_end`. The search order is `last+1`, `last+2`, … modulo N_REQ, ending with `last` itself.
- IDLE on `frame_end`:
  - No `req` bit set: stay IDLE.
  - Otherwise: the winner becomes `owner` and `last`, `hold_cnt`=0, `snap` loads the winner's value, go to OWNED.
- OWNED on `frame_end`:
  - Owner still requesting, `hold_cnt < HOLD_FRAMES-1`: keep owner, `hold_cnt`+1, reload `snap` from the owner's current value.
  - Owner dropped `req`, or `hold_cnt == HOLD_FRAMES-1`: re-arbitrate.
    - Any `req` set: switch to the winner. The same owner may win again if it is the only requester. `hold_cnt`=0 and `snap` loads.
    - No `req` set: go to IDLE, `grant`=0.
- Mid-frame `req` or `value` changes have no effect until the next `frame_end`. A frame in progress always completes from `snap`.
- `nibble` = `snap[4*digit+3 : 4*digit]` in OWNED, and 0 in IDLE. `blank` = 1 in IDLE, 0 in OWNED.
- Reset values:
  - `div_cnt`=0, `digit`=0, `led_id`=8'hFE.
  - `nibble`=0, `blank`=1, `grant`=0, state IDLE.
  - `last`=N_REQ-1, so requester 0 has first priority; `hold_cnt`=0, `snap`=0.
- Reset asserted mid-frame: all registers return to reset values immediately (asynchronously). Scanning restarts at digit 0 after release.

## Timing

- All outputs are registered and change only on a `clk` edge where `tick`=1, apart from asynchronous reset.
- Digit slot lasts SCAN_DIV cycles; frame lasts 4*SCAN_DIV cycles.
- On the `frame_end` edge, these all update together: `digit` wraps to 0, `led_id` becomes FE, `grant`, `blank` and `snap` update, and `nibble` takes the new `snap[3:0]`. No cycle shows a new owner's nibble with an old digit strobe, or the reverse.
- Request-to-grant latency: from 1 cycle up to 4*SCAN_DIV cycles, since a request waits for the next `frame_end`.
- Release latency: the owner keeps `grant` until the first `frame_end` after its `req` falls.
- Starvation bound: with N_REQ continuous requesters, a requester waits at most (N_REQ-1)*HOLD_FRAMES frames.
- `grant` is never multi-hot. `grant` is nonzero if and only if `blank`=0.

## Test plan

Use SCAN_DIV=4, HOLD_FRAMES=2, N_REQ=4 (frame = 16 cycles).

- Reset, no requests for 3 frames → `led_id` cycles FE/FD/FB/F7 every 4 cycles; `blank`=1, `nibble`=0, `grant`=0 throughout.
- `req`=4'b0010, `value[31:16]`=16'h1234 → first `frame_end` gives `grant`=0010, `blank`=0, `nibble` 4,3,2,1 on FE,FD,FB,F7. Sole owner keeps `grant` past the 2-frame hold through re-grant.
- `req`=4'b0101 continuously, values 16'h1111 / 16'h3333 → `grant` sequence 0001 (2 frames), 0100 (2 frames), 0001, …; `nibble` matches the owner's value for each frame.
- Owner 0 drops `req` at digit 1 with no other requesters → frame finishes showing the snapshot. At `frame_end`: `grant`=0, `blank`=1, `led_id`=FE.
- Owner's value changes 16'hAAAA→16'h5555 at digit 2 → digits 2 and 3 still show A. The next frame shows 5 on all digits.
- Assert `rst` for 1 cycle at digit 2 while owned → outputs return to reset values at once. The next grant starts with requester 0 when several request.
